// File: rtl/free_list_mw.sv
// free_list_mw: multi-way physical register free list for the rename stage.
// Allocates up to ALLOC_W and frees up to FREE_W physical registers per cycle.
// A retire head supports full-flush recovery, and NUM_CKPT head snapshots
// support branch-mispredict recovery.
// Optional feature: define FREE_LIST_DBL_FREE_CHECK_EN to build the sticky
// double-free detector behind err_dbl_free (otherwise err_dbl_free is tied 0).
module free_list_mw #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  parameter int NUM_CKPT  = 4,
  localparam int PHYS_W   = $clog2(PHYS_REGS),
  localparam int PTR_W    = PHYS_W + 1,
  localparam int CNT_W    = $clog2(ALLOC_W + 1),
  localparam int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_valid,
  input  logic [ALLOC_W-1:0]        alloc_req,
  output logic                      alloc_ready,
  output logic [ALLOC_W*PHYS_W-1:0] alloc_pd,
  input  logic [FREE_W-1:0]         free_valid,
  input  logic [FREE_W*PHYS_W-1:0]  free_pd,
  input  logic [CNT_W-1:0]          commit_cnt,
  input  logic                      ckpt_save,
  input  logic                      ckpt_restore,
  input  logic [CKPT_W-1:0]         ckpt_id,
  input  logic                      flush_valid,
  output logic [PTR_W-1:0]          free_cnt,
  output logic                      err_dbl_free
);

  localparam int FREE_INIT = PHYS_REGS - ARCH_REGS;

  logic [PHYS_W-1:0] fl_mem [PHYS_REGS];
  logic [PTR_W-1:0]  ckpt   [NUM_CKPT];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  rhead;
  logic [PTR_W-1:0]  tail;

  logic [PTR_W-1:0]  alloc_cnt;
  logic [PTR_W-1:0]  free_inc;
  logic [PTR_W-1:0]  head_alloc;
  logic [PTR_W-1:0]  head_nxt;
  logic [PTR_W-1:0]  commit_ext;
  logic [PHYS_W-1:0] free_addr [FREE_W];
  logic              fire;
  logic              ckpt_we;

  // Pointers carry a wrap bit, so the plain difference is the number of free entries.
  assign free_cnt    = tail - head;
  assign alloc_ready = (free_cnt >= PTR_W'(ALLOC_W));
  assign commit_ext  = PTR_W'(commit_cnt);

  // Each lane reads the entry just past the ones taken by lower-numbered requesting lanes.
  always_comb begin : lane_select
    logic [PTR_W-1:0] run;
    logic [PTR_W-1:0] rd_ptr;
    run      = '0;
    rd_ptr   = '0;
    alloc_pd = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      rd_ptr = head + run;
      alloc_pd[i*PHYS_W +: PHYS_W] = fl_mem[rd_ptr[PHYS_W-1:0]];
      run = run + PTR_W'(alloc_req[i]);
    end
    alloc_cnt = run;
  end

  // Valid free lanes are packed in lane order onto consecutive slots starting at tail.
  always_comb begin : free_compact
    logic [PTR_W-1:0] run;
    logic [PTR_W-1:0] wr_ptr;
    run    = '0;
    wr_ptr = '0;
    for (int i = 0; i < FREE_W; i++) begin
      wr_ptr       = tail + run;
      free_addr[i] = wr_ptr[PHYS_W-1:0];
      run          = run + PTR_W'(free_valid[i]);
    end
    free_inc = run;
  end

  // Head selection: flush beats restore beats a normal all-or-nothing allocation.
  always_comb begin
    fire       = alloc_valid & alloc_ready & ~flush_valid & ~ckpt_restore;
    head_alloc = fire ? (head + alloc_cnt) : head;
    ckpt_we    = ckpt_save & ~flush_valid & ~ckpt_restore;
    if (flush_valid) begin
      head_nxt = rhead + commit_ext;
    end else if (ckpt_restore) begin
      head_nxt = ckpt[ckpt_id];
    end else begin
      head_nxt = head_alloc;
    end
  end

  // Pointer update; commit and frees are non-speculative so they apply on every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      rhead <= '0;
      tail  <= PTR_W'(FREE_INIT);
    end else begin
      head  <= head_nxt;
      rhead <= rhead + commit_ext;
      tail  <= tail + free_inc;
    end
  end

  // Checkpoint slots hold the head as it stands after this cycle's allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        ckpt[i] <= '0;
      end
    end else if (ckpt_we) begin
      ckpt[ckpt_id] <= head_alloc;
    end
  end

  // Storage: reset loads the unmapped registers, commit frees are appended at tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        fl_mem[i] <= (i < FREE_INIT) ? PHYS_W'(ARCH_REGS + i) : '0;
      end
    end else begin
      for (int i = 0; i < FREE_W; i++) begin
        if (free_valid[i]) begin
          fl_mem[free_addr[i]] <= free_pd[i*PHYS_W +: PHYS_W];
        end
      end
    end
  end

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
  logic [PHYS_REGS-1:0] inl;
  logic                 dbl_hit;
  logic                 err_q;
  logic [PHYS_W-1:0]    retire_pd [ALLOC_W];

  // A free is bad if the register is still between rhead and tail or repeats within the group.
  always_comb begin : dbl_detect
    logic [PTR_W-1:0] rt_ptr;
    rt_ptr  = '0;
    dbl_hit = 1'b0;
    for (int i = 0; i < FREE_W; i++) begin
      if (free_valid[i]) begin
        if (inl[free_pd[i*PHYS_W +: PHYS_W]]) begin
          dbl_hit = 1'b1;
        end
        for (int j = 0; j < i; j++) begin
          if (free_valid[j] && (free_pd[j*PHYS_W +: PHYS_W] == free_pd[i*PHYS_W +: PHYS_W])) begin
            dbl_hit = 1'b1;
          end
        end
      end
    end
    for (int k = 0; k < ALLOC_W; k++) begin
      rt_ptr       = rhead + PTR_W'(k);
      retire_pd[k] = fl_mem[rt_ptr[PHYS_W-1:0]];
    end
  end

  // Membership leaves as rhead passes an entry and returns when the register is freed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        inl[i] <= (i >= ARCH_REGS);
      end
      err_q <= 1'b0;
    end else begin
      for (int k = 0; k < ALLOC_W; k++) begin
        if (CNT_W'(k) < commit_cnt) begin
          inl[retire_pd[k]] <= 1'b0;
        end
      end
      for (int i = 0; i < FREE_W; i++) begin
        if (free_valid[i]) begin
          inl[free_pd[i*PHYS_W +: PHYS_W]] <= 1'b1;
        end
      end
      err_q <= err_q | dbl_hit;
    end
  end

  assign err_dbl_free = err_q;
`else
  assign err_dbl_free = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_mw.sv
// tb_free_list_mw: directed bench for free_list_mw with a queue-based model of
// the list contents from the retire head onward, checked every cycle, plus
// hand-computed literal expectations for the documented scenarios.
module tb_free_list_mw;

  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int ALLOC_W   = 2;
  localparam int FREE_W    = 2;
  localparam int NUM_CKPT  = 4;
  localparam int PHYS_W    = 6;
  localparam int PTR_W     = 7;
  localparam int CNT_W     = 2;
  localparam int CKPT_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      alloc_valid;
  logic [ALLOC_W-1:0]        alloc_req;
  logic                      alloc_ready;
  logic [ALLOC_W*PHYS_W-1:0] alloc_pd;
  logic [FREE_W-1:0]         free_valid;
  logic [FREE_W*PHYS_W-1:0]  free_pd;
  logic [CNT_W-1:0]          commit_cnt;
  logic                      ckpt_save;
  logic                      ckpt_restore;
  logic [CKPT_W-1:0]         ckpt_id;
  logic                      flush_valid;
  logic [PTR_W-1:0]          free_cnt;
  logic                      err_dbl_free;

  int checks = 0;
  int errors = 0;

  // Model: lst holds every register from the retire head to the tail in order;
  // used counts how many of them sit before the allocation head.
  int lst[$];
  int alloc_hist[$];
  int used;
  int retired;
  int ckpt_abs[NUM_CKPT];
  bit m_err;
  bit model_valid = 1'b0;

  always #5 clk = ~clk;

  free_list_mw #(
    .PHYS_REGS(PHYS_REGS),
    .ARCH_REGS(ARCH_REGS),
    .ALLOC_W(ALLOC_W),
    .FREE_W(FREE_W),
    .NUM_CKPT(NUM_CKPT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alloc_valid(alloc_valid),
    .alloc_req(alloc_req),
    .alloc_ready(alloc_ready),
    .alloc_pd(alloc_pd),
    .free_valid(free_valid),
    .free_pd(free_pd),
    .commit_cnt(commit_cnt),
    .ckpt_save(ckpt_save),
    .ckpt_restore(ckpt_restore),
    .ckpt_id(ckpt_id),
    .flush_valid(flush_valid),
    .free_cnt(free_cnt),
    .err_dbl_free(err_dbl_free)
  );

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  function automatic int popc_below(input logic [ALLOC_W-1:0] v, input int lane);
    int c = 0;
    for (int i = 0; i < lane; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  function automatic int model_free();
    return lst.size() - used;
  endfunction

  function automatic int model_pd(input int lane, input logic [ALLOC_W-1:0] req);
    return lst[used + popc_below(req, lane)];
  endfunction

  function automatic bit in_list(input int pd);
    foreach (lst[k]) begin
      if (lst[k] == pd) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic idleInputs();
    rst          = 1'b0;
    alloc_valid  = 1'b0;
    alloc_req    = '0;
    free_valid   = '0;
    free_pd      = '0;
    commit_cnt   = '0;
    ckpt_save    = 1'b0;
    ckpt_restore = 1'b0;
    ckpt_id      = '0;
    flush_valid  = 1'b0;
  endtask

  // One clock edge: the model consumes the same inputs the DUT samples.
  task automatic applyStimulus();
    int  n;
    int  cc;
    int  pd;
    bit  fire;
    @(posedge clk);
    if (rst) begin
      lst.delete();
      for (int i = 0; i < PHYS_REGS - ARCH_REGS; i++) lst.push_back(ARCH_REGS + i);
      used    = 0;
      retired = 0;
      for (int i = 0; i < NUM_CKPT; i++) ckpt_abs[i] = 0;
      m_err       = 1'b0;
      model_valid = 1'b1;
    end else begin
      n    = popc_below(alloc_req, ALLOC_W);
      cc   = int'(commit_cnt);
      fire = alloc_valid && (model_free() >= ALLOC_W) && !flush_valid && !ckpt_restore;
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
      for (int i = 0; i < FREE_W; i++) begin
        if (free_valid[i]) begin
          pd = int'(free_pd[i*PHYS_W +: PHYS_W]);
          if (in_list(pd)) m_err = 1'b1;
          for (int j = 0; j < i; j++) begin
            if (free_valid[j] && int'(free_pd[j*PHYS_W +: PHYS_W]) == pd) m_err = 1'b1;
          end
        end
      end
`endif
      if (fire) begin
        for (int i = 0; i < ALLOC_W; i++) begin
          if (alloc_req[i]) alloc_hist.push_back(model_pd(i, alloc_req));
        end
      end
      if (ckpt_save && !flush_valid && !ckpt_restore) begin
        ckpt_abs[ckpt_id] = retired + used + (fire ? n : 0);
      end
      if (flush_valid) used = cc;
      else if (ckpt_restore) used = ckpt_abs[ckpt_id] - retired;
      else if (fire) used = used + n;
      for (int i = 0; i < FREE_W; i++) begin
        if (free_valid[i]) begin
          pd = int'(free_pd[i*PHYS_W +: PHYS_W]);
          lst.push_back(pd);
        end
      end
      repeat (cc) void'(lst.pop_front());
      retired = retired + cc;
      used    = used - cc;
    end
    #1;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
  endtask

  // Every cycle compare the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("free_cnt", int'(free_cnt), model_free());
      checkOutput("alloc_ready", int'(alloc_ready), (model_free() >= ALLOC_W) ? 1 : 0);
      if (model_free() >= ALLOC_W) begin
        for (int i = 0; i < ALLOC_W; i++) begin
          checkOutput($sformatf("alloc_pd_lane%0d", i),
                      int'(alloc_pd[i*PHYS_W +: PHYS_W]), model_pd(i, alloc_req));
        end
      end
      checkOutput("err_dbl_free", int'(err_dbl_free), int'(m_err));
    end
  end

  initial begin
    // Reset state and a full-width group
    doReset();
    checkOutput("t1_free_cnt", int'(free_cnt), 32);
    checkOutput("t1_ready", int'(alloc_ready), 1);
    checkOutput("t1_err", int'(err_dbl_free), 0);
    alloc_valid = 1'b1; alloc_req = 2'b11; #1;
    checkOutput("t1_pd0", int'(alloc_pd[5:0]), 32);
    checkOutput("t1_pd1", int'(alloc_pd[11:6]), 33);
    applyStimulus();
    checkOutput("t1_free_cnt_after", int'(free_cnt), 30);
    checkOutput("t1_pd0_after", int'(alloc_pd[5:0]), 34);
    checkOutput("t1_pd1_after", int'(alloc_pd[11:6]), 35);
    idleInputs();

    // Sparse request mask: lane 1 alone takes the head entry
    doReset();
    alloc_valid = 1'b1; alloc_req = 2'b10; #1;
    checkOutput("t2_lane1", int'(alloc_pd[11:6]), 32);
    applyStimulus();
    idleInputs();
    alloc_valid = 1'b1; alloc_req = 2'b01; #1;
    checkOutput("t2_lane0_next", int'(alloc_pd[5:0]), 33);
    applyStimulus();
    idleInputs();

    // Drain until one entry is left, then frees make the list ready again
    doReset();
    alloc_valid = 1'b1; alloc_req = 2'b11;
    repeat (15) applyStimulus();
    alloc_req = 2'b01;
    applyStimulus();
    idleInputs();
    checkOutput("t3_free_cnt_low", int'(free_cnt), 1);
    checkOutput("t3_not_ready", int'(alloc_ready), 0);
    alloc_valid = 1'b1; alloc_req = 2'b11;
    free_valid = 2'b11; free_pd = {6'd6, 6'd5};
    applyStimulus();
    idleInputs();
    checkOutput("t3_free_cnt_refill", int'(free_cnt), 3);
    checkOutput("t3_ready_again", int'(alloc_ready), 1);
    alloc_req = 2'b11; #1;
    checkOutput("t3_order_63", int'(alloc_pd[5:0]), 63);
    checkOutput("t3_order_5", int'(alloc_pd[11:6]), 5);
    alloc_valid = 1'b1;
    applyStimulus();
    idleInputs();
    alloc_req = 2'b01; #1;
    checkOutput("t3_order_6", int'(alloc_pd[5:0]), 6);
    idleInputs();

    // Checkpoint save without and with a firing group, then restores
    doReset();
    alloc_valid = 1'b1; alloc_req = 2'b11;
    repeat (2) applyStimulus();
    idleInputs();
    ckpt_save = 1'b1; ckpt_id = 2'd2;
    applyStimulus();
    idleInputs();
    alloc_valid = 1'b1; alloc_req = 2'b11;
    repeat (3) applyStimulus();
    idleInputs();
    checkOutput("t4_free_cnt_pre", int'(free_cnt), 22);
    ckpt_restore = 1'b1; ckpt_id = 2'd2; alloc_valid = 1'b1; alloc_req = 2'b11;
    applyStimulus();
    idleInputs();
    checkOutput("t4_free_cnt_restored", int'(free_cnt), 28);
    alloc_req = 2'b11; #1;
    checkOutput("t4_pd0_restored", int'(alloc_pd[5:0]), 36);
    checkOutput("t4_pd1_restored", int'(alloc_pd[11:6]), 37);
    alloc_valid = 1'b1; ckpt_save = 1'b1; ckpt_id = 2'd1;
    applyStimulus();
    idleInputs();
    checkOutput("t4_free_cnt_save_fire", int'(free_cnt), 26);
    alloc_valid = 1'b1; alloc_req = 2'b11;
    applyStimulus();
    idleInputs();
    ckpt_restore = 1'b1; ckpt_id = 2'd1;
    applyStimulus();
    idleInputs();
    checkOutput("t4_free_cnt_restore1", int'(free_cnt), 26);
    alloc_req = 2'b01; #1;
    checkOutput("t4_pd0_restore1", int'(alloc_pd[5:0]), 38);
    idleInputs();

    // Flush with a same-cycle commit and concurrent frees
    doReset();
    alloc_valid = 1'b1; alloc_req = 2'b11;
    repeat (2) applyStimulus();
    commit_cnt = 2'd2;
    repeat (2) applyStimulus();
    commit_cnt = 2'd0;
    applyStimulus();
    idleInputs();
    checkOutput("t5_free_cnt_pre", int'(free_cnt), 22);
    flush_valid = 1'b1; commit_cnt = 2'd2; free_valid = 2'b11; free_pd = {6'd8, 6'd7};
    alloc_valid = 1'b1; alloc_req = 2'b11; ckpt_save = 1'b1; ckpt_id = 2'd0;
    applyStimulus();
    idleInputs();
    checkOutput("t5_free_cnt_flush", int'(free_cnt), 28);
    alloc_req = 2'b11; #1;
    checkOutput("t5_pd0_flush", int'(alloc_pd[5:0]), 38);
    checkOutput("t5_pd1_flush", int'(alloc_pd[11:6]), 39);
    idleInputs();

    // Reset in the middle of activity returns to the reset state
    alloc_valid = 1'b1; alloc_req = 2'b11; free_valid = 2'b11; free_pd = {6'd10, 6'd9};
    commit_cnt = 2'd1; rst = 1'b1;
    applyStimulus();
    idleInputs();
    checkOutput("t7_free_cnt_reset", int'(free_cnt), 32);
    alloc_req = 2'b11; #1;
    checkOutput("t7_pd0_reset", int'(alloc_pd[5:0]), 32);
    checkOutput("t7_pd1_reset", int'(alloc_pd[11:6]), 33);
    idleInputs();

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    // Freeing a register that is still in the list sets a sticky error
    doReset();
    free_valid = 2'b01; free_pd = {6'd0, 6'd40};
    applyStimulus();
    idleInputs();
    checkOutput("t6_err_set", int'(err_dbl_free), 1);
    repeat (3) applyStimulus();
    checkOutput("t6_err_sticky", int'(err_dbl_free), 1);
    doReset();
    checkOutput("t6_err_cleared", int'(err_dbl_free), 0);
`endif

    // Steady alloc/commit/free traffic long enough to wrap the pointers
    doReset();
    alloc_hist.delete();
    for (int k = 0; k < 80; k++) begin
      idleInputs();
      alloc_valid = 1'b1; alloc_req = 2'b11;
      if (k >= 1) commit_cnt = 2'd2;
      if (k >= 2) begin
        free_valid = 2'b11;
        free_pd[5:0]  = PHYS_W'(alloc_hist[2*(k-2)]);
        free_pd[11:6] = PHYS_W'(alloc_hist[2*(k-2)+1]);
      end
      applyStimulus();
    end
    idleInputs();
    applyStimulus();
    checkOutput("t8_free_cnt_wrap", int'(free_cnt), 28);
    checkOutput("t8_err_wrap", int'(err_dbl_free), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
